// File: rtl/mips_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_muldiv_unit_if
// Brief    : Issue/result bundle between the EX stage and the mul/div unit.
// Revision : 1.0
// ============================================================================
interface mips_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, div0, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_muldiv_unit
// Brief    : Iterative radix-2 multiply/divide unit with HI/LO registers.
//            MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// Revision : 1.0
// ============================================================================
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mips_muldiv_unit_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_raw_a;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div0;

    logic               w_is_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_part;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_step_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_mag;
    logic [WIDTH-1:0]   w_rem_mag;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_is_signed = (bus.op == c_OP_MULT) || (bus.op == c_OP_DIV);
    assign w_a_neg     = w_is_signed & bus.a[WIDTH-1];
    assign w_b_neg     = w_is_signed & bus.b[WIDTH-1];
    // |MIN| wraps to MIN, which read as unsigned is exactly 2**(WIDTH-1).
    assign w_abs_a     = w_a_neg ? -bus.a : bus.a;
    assign w_abs_b     = w_b_neg ? -bus.b : bus.b;

    // Shift-add: multiplier sits in the low half and shifts out as product bits shift in.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                        (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide over the remainder:quotient pair; remainder < divisor keeps WIDTH+1 bits enough.
    assign w_div_part  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_trial = w_div_part - {1'b0, r_opnd};
    assign w_div_next  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                            : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    assign w_step_next = r_is_div ? w_div_next : w_mul_next;

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quot_mag = r_acc[WIDTH-1:0];
    assign w_rem_mag  = r_acc[2*WIDTH-1:WIDTH];
    assign w_quot_fix = r_neg_q ? -w_quot_mag : w_quot_mag;
    assign w_rem_fix  = r_neg_r ? -w_rem_mag : w_rem_mag;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;

    // Extending to 2*WIDTH first makes the truncated product correct for both signednesses.
    assign w_ext_a     = {{WIDTH{w_is_signed & bus.a[WIDTH-1]}}, bus.a};
    assign w_ext_b     = {{WIDTH{w_is_signed & bus.b[WIDTH-1]}}, bus.b};
    assign w_fast_prod = w_ext_a * w_ext_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_raw_a  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        if (bus.op == c_OP_MTHI) begin
                            r_hi <= bus.a;
                        end else if (bus.op == c_OP_MTLO) begin
                            r_lo <= bus.a;
                        end else if (!bus.op[2]) begin
                            r_is_div <= bus.op[1];
                            r_raw_a  <= bus.a;
                            r_b_zero <= (bus.b == '0);
                            r_cnt    <= '0;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            if (bus.op[1]) begin
                                r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                                r_opnd  <= w_abs_b;
                                r_state <= c_ST_RUN;
                            end else begin
`ifdef MULDIV_FAST_MUL_EN
                                r_acc   <= w_fast_prod;
                                r_opnd  <= w_abs_a;
                                r_neg_q <= 1'b0;
                                r_state <= c_ST_FIX;
`else
                                r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                                r_opnd  <= w_abs_a;
                                r_state <= c_ST_RUN;
`endif
                            end
                        end
                    end
                end
                c_ST_RUN: begin
                    if (bus.cancel) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_acc <= w_step_next;
                        r_cnt <= r_cnt + c_CNT_ONE;
                        if (r_cnt == c_LAST_STEP) begin
                            r_state <= c_ST_FIX;
                        end
                    end
                end
                c_ST_FIX: begin
                    r_state <= c_ST_IDLE;
                    if (!bus.cancel) begin
                        r_done <= 1'b1;
                        r_div0 <= r_is_div & r_b_zero;
                        if (!r_is_div) begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end else if (r_b_zero) begin
                            r_hi <= r_raw_a;
                            r_lo <= {WIDTH{1'b1}};
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state != c_ST_IDLE);
    assign bus.done = r_done;
    assign bus.div0 = r_div0;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_muldiv_unit
// Brief    : Directed self-checking bench for mips_muldiv_unit (WIDTH=32).
// Revision : 1.0
// ============================================================================
module tb_mips_muldiv_unit;

    localparam logic [2:0] c_MULT  = 3'b000;
    localparam logic [2:0] c_MULTU = 3'b001;
    localparam logic [2:0] c_DIV   = 3'b010;
    localparam logic [2:0] c_DIVU  = 3'b011;
    localparam logic [2:0] c_MTHI  = 3'b100;
    localparam logic [2:0] c_MTLO  = 3'b101;
`ifdef MULDIV_FAST_MUL_EN
    localparam int c_MUL_LAT = 1;
`else
    localparam int c_MUL_LAT = 33;
`endif
    localparam int c_DIV_LAT = 33;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mips_muldiv_unit_if #(.WIDTH(32)) bus ();

    mips_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one op for exactly one rising edge (E0); returns at the falling edge after E0.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts cycles after E0 until done, and how many of those had busy high.
    task automatic wait_done(output int lat, output int busy_cnt, output bit timed_out);
        lat       = 0;
        busy_cnt  = 0;
        timed_out = 1'b0;
        while (bus.done !== 1'b1) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (lat >= 100) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.hi !== 32'h0)   begin n_errors++; $display("FAIL reset_hi: got %h want %h", bus.hi, 32'h0); end
        n_checks++; if (bus.lo !== 32'h0)   begin n_errors++; $display("FAIL reset_lo: got %h want %h", bus.lo, 32'h0); end
        n_checks++; if (bus.busy !== 1'b0)  begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0)  begin n_errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_checks++; if (bus.div0 !== 1'b0)  begin n_errors++; $display("FAIL reset_div0: got %b want 0", bus.div0); end
    endtask

    task automatic test_op(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_div0);
        int lat; int bcnt; bit to;
        issue(op, a, b);
        wait_done(lat, bcnt, to);
        n_checks++;
        if (to) begin
            n_errors++; $display("FAIL %s_timeout: got no done want done at %0d", name, exp_lat);
        end else begin
            if (lat !== exp_lat)     begin n_errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); end
            n_checks++; if (bcnt !== exp_lat) begin n_errors++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, bcnt, exp_lat); end
            n_checks++; if (bus.hi !== exp_hi)   begin n_errors++; $display("FAIL %s_hi: got %h want %h", name, bus.hi, exp_hi); end
            n_checks++; if (bus.lo !== exp_lo)   begin n_errors++; $display("FAIL %s_lo: got %h want %h", name, bus.lo, exp_lo); end
            n_checks++; if (bus.div0 !== exp_div0) begin n_errors++; $display("FAIL %s_div0: got %b want %b", name, bus.div0, exp_div0); end
            n_checks++; if (bus.busy !== 1'b0)   begin n_errors++; $display("FAIL %s_busy_at_done: got %b want 0", name, bus.busy); end
            @(negedge clk);
            n_checks++; if (bus.done !== 1'b0)   begin n_errors++; $display("FAIL %s_done_pulse: got %b want 0", name, bus.done); end
        end
    endtask

    task automatic test_multiply();
        test_op("multu_max", c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c_MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        test_op("mult_neg",  c_MULT,  32'hFFFF_FFFD, 32'h0000_0005, c_MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    endtask

    task automatic test_divide();
        test_op("div_neg",  c_DIV,  32'hFFFF_FFF9, 32'h0000_0002, c_DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        test_op("divu",     c_DIVU, 32'h0000_0007, 32'h0000_0002, c_DIV_LAT, 32'h0000_0001, 32'h0000_0003, 1'b0);
        test_op("div_ovf",  c_DIV,  32'h8000_0000, 32'hFFFF_FFFF, c_DIV_LAT, 32'h0000_0000, 32'h8000_0000, 1'b0);
    endtask

    task automatic test_div_zero();
        test_op("divu_zero", c_DIVU, 32'h0000_0064, 32'h0000_0000, c_DIV_LAT, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        test_op("div0_clr",  c_MULTU, 32'h0000_0002, 32'h0000_0003, c_MUL_LAT, 32'h0000_0000, 32'h0000_0006, 1'b0);
        test_op("div_zero_neg", c_DIV, 32'hFFFF_FFF9, 32'h0000_0000, c_DIV_LAT, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    endtask

    task automatic test_control();
        bit saw_done;
        issue(c_MTHI, 32'h0000_1234, 32'h0);
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_errors++; $display("FAIL mthi_flags: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        issue(c_MTLO, 32'h0000_5678, 32'h0);
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_errors++; $display("FAIL mtlo_flags: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        n_checks++; if (bus.hi !== 32'h0000_1234) begin n_errors++; $display("FAIL mthi_value: got %h want %h", bus.hi, 32'h1234); end
        n_checks++; if (bus.lo !== 32'h0000_5678) begin n_errors++; $display("FAIL mtlo_value: got %h want %h", bus.lo, 32'h5678); end
        // cancel together with a start in IDLE drops the start
        @(negedge clk);
        bus.start = 1'b1; bus.op = c_MTHI; bus.a = 32'hDEAD_BEEF; bus.cancel = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        n_checks++; if (bus.hi !== 32'h0000_1234) begin n_errors++; $display("FAIL cancel_drops_start: got %h want %h", bus.hi, 32'h1234); end
        issue(c_DIV, 32'h0000_0064, 32'h0000_0007);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = c_MULTU; bus.a = 32'h1; bus.b = 32'h1;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL busy_mid_div: got %b want 1", bus.busy); end
        repeat (4) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL cancel_busy: got %b want 0", bus.busy); end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (saw_done) begin n_errors++; $display("FAIL cancel_no_done: got done=1 want done=0"); end
        n_checks++; if (bus.hi !== 32'h0000_1234) begin n_errors++; $display("FAIL cancel_hi: got %h want %h", bus.hi, 32'h1234); end
        n_checks++; if (bus.lo !== 32'h0000_5678) begin n_errors++; $display("FAIL cancel_lo: got %h want %h", bus.lo, 32'h5678); end
    endtask

    task automatic test_reset_mid_op();
        issue(c_MULT, 32'h0000_0009, 32'h0000_000B);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.hi !== 32'h0)  begin n_errors++; $display("FAIL midrst_hi: got %h want %h", bus.hi, 32'h0); end
        n_checks++; if (bus.lo !== 32'h0)  begin n_errors++; $display("FAIL midrst_lo: got %h want %h", bus.lo, 32'h0); end
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_errors++; $display("FAIL midrst_flags: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        test_op("after_rst", c_MULTU, 32'h0000_0004, 32'h0000_0004, c_MUL_LAT, 32'h0000_0000, 32'h0000_0010, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_op("b2b_mult_pos", c_MULT, 32'h0001_0000, 32'h0001_0000, c_MUL_LAT, 32'h0000_0001, 32'h0000_0000, 1'b0);
        test_op("b2b_div_negb", c_DIV,  32'h0000_0007, 32'hFFFF_FFFE, c_DIV_LAT, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'b000;
        bus.a      = 32'h0;
        bus.b      = 32'h0;
        bus.cancel = 1'b0;
        test_reset();
        test_multiply();
        test_divide();
        test_div_zero();
        test_control();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
